// File: rtl/fifo_reader.sv
// Drain engine for a synchronous FIFO read port: issues credit-limited read strobes,
// captures the registered read data and re-presents it through a 3-entry valid/ready buffer.
module fifo_reader #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic             busy,
    output logic [CNT_W-1:0] words_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [1:0]       occ;
    logic             inflight;
    logic [1:0]       head;
    logic [1:0]       tail;
    logic [WIDTH-1:0] mem [3];
    logic [2:0]       credit_used;
    logic             pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A strobe is only issued when both the buffer and the word already in flight fit in 3 slots.
    assign credit_used = {1'b0, occ} + {2'b00, inflight};
    assign fifo_rd_en  = (state == RUN) && !fifo_empty && (credit_used < 3'd3);
    assign m_valid     = (occ != 2'd0);
    assign m_data      = mem[head];
    assign pop         = m_valid && m_ready;
    assign busy        = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = RUN;
            RUN:     if (!enable) state_next = DRAIN;
            DRAIN: begin
                if (enable)
                    state_next = RUN;
                else if (!inflight && (occ == 2'd0))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture and pop may coincide; the tail slot is always free so the head word is never disturbed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            occ       <= 2'd0;
            inflight  <= 1'b0;
            head      <= 2'd0;
            tail      <= 2'd0;
            words_out <= '0;
            for (int i = 0; i < 3; i++)
                mem[i] <= '0;
        end else begin
            state    <= state_next;
            inflight <= fifo_rd_en;
            if (inflight) begin
                mem[tail] <= fifo_data;
                tail      <= ptr_inc(tail);
            end
            if (pop) begin
                head      <= ptr_inc(head);
                words_out <= words_out + CNT_W'(1);
            end
            case ({inflight, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: directed latency/stall/drain/reset scenarios plus a
// randomized run scored against a queue-based model of the FIFO and the delivered stream.
module tb_fifo_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_rd_en;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready = 1'b0;
    logic        busy;
    logic [15:0] words_out;

    logic        rd_en4;
    logic        m_valid4;
    logic [7:0]  m_data4;
    logic        busy4;
    logic [3:0]  words_out4;

    logic [7:0]  fq[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  w_model;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    fifo_reader #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .busy(busy), .words_out(words_out)
    );

    fifo_reader #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_en(rd_en4), .m_valid(m_valid4), .m_data(m_data4),
        .m_ready(m_ready), .busy(busy4), .words_out(words_out4)
    );

    // FIFO model: registered read data one cycle after a strobe, registered empty flag.
    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() > 0) begin
            w_model = fq.pop_front();
            fifo_data <= w_model;
            exp_q.push_back(w_model);
        end
        fifo_empty <= (fq.size() == 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        m_ready = 1'b0;
        fq.delete();
        exp_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #2;
        n_checks++;
        if ({fifo_rd_en, m_valid, busy, m_data, words_out} !== 27'h0)
            $display("FAIL reset_outputs got rd=%b v=%b busy=%b data=%h words=%0d want all zero",
                     fifo_rd_en, m_valid, busy, m_data, words_out);
        else n_pass++;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if ({fifo_rd_en, m_valid, busy, m_data, words_out, m_valid4, words_out4} !== 32'h0)
            $display("FAIL reset_release got rd=%b v=%b busy=%b data=%h words=%0d want all zero",
                     fifo_rd_en, m_valid, busy, m_data, words_out);
        else n_pass++;
        tick();
    endtask

    task automatic test_stream();
        logic [9:0]  rd_bits = '0;
        logic [9:0]  hs_bits = '0;
        logic [31:0] hs_data = '0;
        do_reset();
        fq = '{8'h11, 8'h22, 8'h33, 8'h44};
        m_ready = 1'b1;
        enable  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rd_bits[i] = fifo_rd_en;
            if (m_valid && m_ready) begin
                hs_bits[i] = 1'b1;
                hs_data = {hs_data[23:0], m_data};
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (rd_bits !== 10'b0000011110) $display("FAIL stream_strobes got %b want %b", rd_bits, 10'b0000011110);
        else n_pass++;
        n_checks++;
        if (hs_bits !== 10'b0001111000) $display("FAIL stream_valid_cycles got %b want %b", hs_bits, 10'b0001111000);
        else n_pass++;
        n_checks++;
        if (hs_data !== 32'h11223344) $display("FAIL stream_data got %h want %h", hs_data, 32'h11223344);
        else n_pass++;
        n_checks++;
        if (words_out !== 16'd4) $display("FAIL stream_words got %0d want 4", words_out);
        else n_pass++;
        tick();
    endtask

    task automatic test_stall();
        int          strobes = 0;
        logic        held_ok = 1'b1;
        logic [17:0] rd_bits = '0;
        logic [17:0] hs_bits = '0;
        logic [31:0] hs_data = '0;
        do_reset();
        fq = '{8'h11, 8'h22, 8'h33, 8'h44};
        m_ready = 1'b0;
        enable  = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i == 8) m_ready = 1'b1;
            @(negedge clk);
            if (i < 8 && fifo_rd_en) strobes++;
            if (i >= 3 && i < 8 && (!m_valid || m_data !== 8'h11)) held_ok = 1'b0;
            if (i == 7) begin
                n_checks++;
                if (strobes != 3) $display("FAIL stall_strobe_count got %0d want 3", strobes);
                else n_pass++;
                n_checks++;
                if ({m_valid, m_data} !== {1'b1, 8'h11})
                    $display("FAIL stall_head got v=%b data=%h want v=1 data=11", m_valid, m_data);
                else n_pass++;
            end
            rd_bits[i] = fifo_rd_en;
            if (m_valid && m_ready) begin
                hs_bits[i] = 1'b1;
                hs_data = {hs_data[23:0], m_data};
            end
            tick();
        end
        n_checks++;
        if (!held_ok) $display("FAIL stall_hold got unstable head want 11 held");
        else n_pass++;
        n_checks++;
        if (rd_bits[17:8] !== 10'b0000000010)
            $display("FAIL stall_resume_strobe got %b want %b", rd_bits[17:8], 10'b0000000010);
        else n_pass++;
        n_checks++;
        if ({hs_bits, hs_data} !== {18'b000000111100000000, 32'h11223344})
            $display("FAIL stall_release got cycles=%b data=%h want cycles=%b data=11223344",
                     hs_bits, hs_data, 18'b000000111100000000);
        else n_pass++;
    endtask

    task automatic test_drain();
        logic [9:0] rd_bits = '0;
        logic [9:0] busy_bits = '0;
        logic [9:0] hs_bits = '0;
        logic [7:0] hs_word = '0;
        do_reset();
        fq = '{8'h11, 8'h22, 8'h33, 8'h44};
        m_ready = 1'b1;
        enable  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 1) enable = 1'b0;
            @(negedge clk);
            rd_bits[i]   = fifo_rd_en;
            busy_bits[i] = busy;
            if (m_valid && m_ready) begin
                hs_bits[i] = 1'b1;
                hs_word = m_data;
            end
            tick();
        end
        n_checks++;
        if (rd_bits !== 10'b0000000010) $display("FAIL drain_strobes got %b want %b", rd_bits, 10'b0000000010);
        else n_pass++;
        n_checks++;
        if ({hs_bits, hs_word} !== {10'b0000001000, 8'h11})
            $display("FAIL drain_delivery got cycles=%b word=%h want cycles=0000001000 word=11", hs_bits, hs_word);
        else n_pass++;
        n_checks++;
        if (busy_bits !== 10'b0000011110) $display("FAIL drain_busy got %b want %b", busy_bits, 10'b0000011110);
        else n_pass++;
        n_checks++;
        if (words_out !== 16'd1) $display("FAIL drain_words got %0d want 1", words_out);
        else n_pass++;
    endtask

    task automatic test_empty_gap();
        logic [13:0] rd_bits = '0;
        logic [13:0] busy_bits = '0;
        logic [13:0] hs_bits = '0;
        logic [23:0] hs_data = '0;
        logic        rd_on_empty = 1'b0;
        do_reset();
        fq = '{8'hA1, 8'hA2};
        m_ready = 1'b1;
        enable  = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i == 6) fq.push_back(8'h5A);
            @(negedge clk);
            rd_bits[i]   = fifo_rd_en;
            busy_bits[i] = busy;
            if (fifo_rd_en && fifo_empty) rd_on_empty = 1'b1;
            if (m_valid && m_ready) begin
                hs_bits[i] = 1'b1;
                hs_data = {hs_data[15:0], m_data};
            end
            tick();
        end
        n_checks++;
        if (rd_bits !== 14'b00000010000110) $display("FAIL gap_strobes got %b want %b", rd_bits, 14'b00000010000110);
        else n_pass++;
        n_checks++;
        if (rd_on_empty) $display("FAIL gap_strobe_on_empty got strobe while empty want none");
        else n_pass++;
        n_checks++;
        if (busy_bits !== 14'b11111111111110) $display("FAIL gap_stays_run got %b want %b", busy_bits, 14'b11111111111110);
        else n_pass++;
        n_checks++;
        if ({hs_bits, hs_data} !== {14'b00001000011000, 24'hA1A25A})
            $display("FAIL gap_delivery got cycles=%b data=%h want cycles=00001000011000 data=a1a25a", hs_bits, hs_data);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic rd_seen = 1'b0;
        logic busy_seen = 1'b0;
        do_reset();
        fq = '{8'h11, 8'h22, 8'h33, 8'h44};
        m_ready = 1'b0;
        enable  = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if ({m_valid, busy, exp_q.size() == 3} !== 3'b111)
            $display("FAIL midreset_setup got v=%b busy=%b outstanding=%0d want 1 1 3", m_valid, busy, exp_q.size());
        else n_pass++;
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({fifo_rd_en, m_valid, busy, m_data, words_out, m_valid4, busy4} !== 29'h0)
            $display("FAIL midreset_async got rd=%b v=%b busy=%b data=%h words=%0d want all zero",
                     fifo_rd_en, m_valid, busy, m_data, words_out);
        else n_pass++;
        enable = 1'b0;
        exp_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (fifo_rd_en) rd_seen = 1'b1;
            if (busy || m_valid) busy_seen = 1'b1;
            tick();
        end
        n_checks++;
        if ({rd_seen, busy_seen} !== 2'b00)
            $display("FAIL midreset_idle got strobe=%b active=%b want 0 0", rd_seen, busy_seen);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int cnt = 0;
        int last_checked = -1;
        do_reset();
        for (int k = 0; k < 17; k++) fq.push_back(8'(k + 1));
        m_ready = 1'b1;
        enable  = 1'b1;
        for (int i = 0; i < 60 && last_checked < 17; i++) begin
            @(negedge clk);
            if (cnt >= 15 && cnt != last_checked) begin
                n_checks++;
                if (words_out4 !== 4'(cnt))
                    $display("FAIL wrap_count_%0d got %0d want %0d", cnt, words_out4, cnt % 16);
                else n_pass++;
                last_checked = cnt;
            end
            if (m_valid && m_ready) cnt++;
            tick();
        end
        n_checks++;
        if (last_checked != 17 || words_out !== 16'd17)
            $display("FAIL wrap_complete got delivered=%0d words=%0d want 17 17", last_checked, words_out);
        else n_pass++;
    endtask

    task automatic test_random();
        int delivered = 0;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 520; i++) begin
            if (i < 500) begin
                if ($urandom_range(0, 7) == 0) enable = ~enable;
                m_ready = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 1) == 1 && fq.size() < 8) fq.push_back(8'($urandom));
            end else begin
                enable  = 1'b0;
                m_ready = 1'b1;
            end
            @(negedge clk);
            n_checks++;
            if (fifo_rd_en && fifo_empty) $display("FAIL rand_strobe_on_empty cycle %0d got strobe want none", i);
            else n_pass++;
            n_checks++;
            if (exp_q.size() > 3) $display("FAIL rand_credit cycle %0d got %0d outstanding want <=3", i, exp_q.size());
            else n_pass++;
            n_checks++;
            if (words_out !== 16'(delivered) || words_out4 !== 4'(delivered))
                $display("FAIL rand_words cycle %0d got %0d/%0d want %0d", i, words_out, words_out4, delivered);
            else n_pass++;
            if (m_valid) begin
                n_checks++;
                if (exp_q.size() == 0)
                    $display("FAIL rand_data cycle %0d got %h want no valid word", i, m_data);
                else if (m_data !== exp_q[0])
                    $display("FAIL rand_data cycle %0d got %h want %h", i, m_data, exp_q[0]);
                else n_pass++;
                if (m_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    delivered++;
                end
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if ({busy, m_valid, exp_q.size() == 0} !== 3'b001)
            $display("FAIL rand_drained got busy=%b v=%b outstanding=%0d want 0 0 0", busy, m_valid, exp_q.size());
        else n_pass++;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_drain();
        test_empty_gap();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Drain engine for the team's synchronous FIFO read port. It issues read strobes against the FIFO's `empty` flag and captures each word from the FIFO's registered data output, which arrives one cycle after the strobe. It then re-presents the words on a valid/ready stream through a 3-entry output buffer, so downstream back-pressure never has a combinational path back to the FIFO. It sits between any FIFO instance and its consumer and sustains one word per cycle when the consumer is always ready.

## Interface
- `WIDTH`, 8, data word width; must match the attached FIFO.
- `CNT_W`, 16, width of the delivered-word counter.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `enable`  in  1  level; 1 = fetch from FIFO, 0 = stop fetching and drain.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  WIDTH  FIFO registered read data; valid the cycle after an accepted strobe.
- `fifo_rd_en`  out  1  read strobe to FIFO (combinational).
- `m_valid`  out  1  output word available.
- `m_data`  out  WIDTH  output word (registered buffer head).
- `m_ready`  in  1  consumer accepts when `m_valid && m_ready`.
- `busy`  out  1  state != IDLE.
- `words_out`  out  CNT_W  count of delivered words, wraps modulo 2^CNT_W.

## Operation
- States:
  - IDLE: no reads.
  - RUN: reads allowed.
  - DRAIN: no new reads; flushes the in-flight word and the buffer.
- Transitions (evaluated each edge):
  - IDLE→RUN when `enable`=1.
  - RUN→DRAIN when `enable`=0.
  - DRAIN→RUN when `enable`=1.
  - DRAIN→IDLE when `enable`=0, `inflight`=0 and `occ`=0.
- `occ` (0..3) is the number of buffered words. `inflight` (0/1) is a strobe issued in the previous cycle.
- `fifo_rd_en` = (state==RUN) && !`fifo_empty` && (`occ` + `inflight` < 3).
  - No dependence on `m_ready`.
- Capture: when `inflight`=1, `fifo_data` is written at the buffer tail on that edge, and `inflight` follows the current `fifo_rd_en`.
- Pop: when `m_valid && m_ready`, the head advances and `words_out` increments.
- Capture and pop in the same cycle: `occ` is unchanged and order is preserved.
- The credit rule guarantees a capture never finds `occ`=3; no word is ever dropped or overwritten.
- `m_valid` = (`occ`!=0). `m_data` is held stable while `m_valid && !m_ready`.
- `m_data` is don't-care when `m_valid`=0 but must not be X after reset.
- A word captured in DRAIN is still delivered.
- `enable` deassertion never discards data.

## Timing
- Reset values:
  - `m_valid`=0, `m_data`=0, `busy`=0, `words_out`=0.
  - `occ`=0, `inflight`=0, state=IDLE; therefore `fifo_rd_en`=0.
- Reset asserted mid-operation clears everything immediately, including any in-flight or buffered word. Those words are lost by design.
- Latency: strobe in cycle t → word captured at the end of t+1 → `m_valid`=1 in t+2, when the buffer was empty.
- `enable` rise → first possible strobe in the cycle after the IDLE→RUN edge.
- Throughput: one strobe per cycle in steady state with `m_ready`=1 and the FIFO non-empty.
- Stall: with `m_ready`=0, at most 3 strobes are issued before `fifo_rd_en` stays low. Strobing resumes the cycle after the first pop frees credit.
- `words_out` wraps from 2^CNT_W−1 to 0 without a flag.

## Test plan
- Reset, then `enable`=1; FIFO holds 0x11,0x22,0x33,0x44; `m_ready`=1 → `fifo_rd_en` high for 4 consecutive cycles. The stream emits 0x11..0x44 on consecutive cycles, the first at strobe+2. `words_out`=4.
- Same data with `m_ready`=0 → exactly 3 strobes, `m_valid`=1, and `m_data`=0x11 held. After raising `m_ready`, all 4 words arrive in order and the 4th strobe occurs one cycle after the first pop.
- `enable` dropped the cycle after a strobe → state DRAIN and no further strobes. The in-flight word is delivered, `busy` falls after the last pop, and state returns to IDLE.
- FIFO goes empty after 2 words with `enable` held → `fifo_rd_en`=0 while `fifo_empty`=1 and state stays RUN. A new word 0x5A is read and delivered once empty clears.
- `reset_n` pulsed low with `occ`=2 and `inflight`=1 → all outputs return to reset values asynchronously. After release with `enable`=0, no strobe is issued.
- `CNT_W`=4, 17 words delivered → `words_out` reads 15 after 15 words, then 0, then 1.
